// File: rtl/spike_encoder_8ch.sv
// Latency (time-to-first-spike) encoder for eight channels.
// A frame runs 2**p_width cycles; channel i first fires at t = max - I_i and
// then every p_isi cycles, up to p_spike_num spikes, never past frame end.
// Intensity 0 is silent. After the frame a p_gap-cycle refractory period runs,
// then o_done pulses for the first IDLE cycle.
//
// Start handshake: i_start is a request sampled only while the FSM is IDLE
// (including the o_done cycle); it is accepted on that clock edge, with the
// intensities captured on the same edge. While o_busy is high i_start is ignored.
module spike_encoder_8ch #(
  parameter int p_width     = 8,
  parameter int p_spike_num = 2,
  parameter int p_isi       = 16,
  parameter int p_gap       = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [p_width-1:0] i_intensity_1,
  input  logic [p_width-1:0] i_intensity_2,
  input  logic [p_width-1:0] i_intensity_3,
  input  logic [p_width-1:0] i_intensity_4,
  input  logic [p_width-1:0] i_intensity_5,
  input  logic [p_width-1:0] i_intensity_6,
  input  logic [p_width-1:0] i_intensity_7,
  input  logic [p_width-1:0] i_intensity_8,
  output logic [8:1]         o_event,
  output logic [p_width-1:0] o_time,
  output logic               o_busy,
  output logic               o_done
);

  // Next-fire time is wide enough to hold the latest possible scheduled spike,
  // so it never wraps back into the frame.
  localparam int NFW = p_width + $clog2(p_spike_num * p_isi + 1);
  localparam int CW  = $clog2(p_spike_num + 1);
  localparam int GW  = $clog2(p_gap + 1);
  localparam logic [p_width-1:0] T_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t             state_q, state_d;
  logic [p_width-1:0] t_q, t_d;
  logic [8:1]         ev_q, ev_d;
  logic               done_q, done_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [NFW-1:0]     nf_q [8];
  logic [NFW-1:0]     nf_d [8];
  logic [CW-1:0]      c_q  [8];
  logic [CW-1:0]      c_d  [8];
  logic [7:0]         nz_q, nz_d;
  logic               match_en;
  logic [p_width-1:0] intens [8];

  assign intens[0] = i_intensity_1;
  assign intens[1] = i_intensity_2;
  assign intens[2] = i_intensity_3;
  assign intens[3] = i_intensity_4;
  assign intens[4] = i_intensity_5;
  assign intens[5] = i_intensity_6;
  assign intens[6] = i_intensity_7;
  assign intens[7] = i_intensity_8;

  // Next-state, frame counter and firing decisions; spikes are matched against
  // the next value of t so the registered event lines up with o_time.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    ev_d     = '0;
    done_d   = 1'b0;
    gap_d    = gap_q;
    nf_d     = nf_q;
    c_d      = c_q;
    nz_d     = nz_q;
    match_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = RUN;
          t_d      = '0;
          match_en = 1'b1;
          for (int i = 0; i < 8; i++) begin
            nz_d[i] = (intens[i] != '0);
            nf_d[i] = NFW'(T_MAX - intens[i]);
            c_d[i]  = '0;
          end
        end
      end
      RUN: begin
        if (t_q == T_MAX) begin
          state_d = GAP;
          t_d     = '0;
          gap_d   = '0;
        end else begin
          t_d      = t_q + 1'b1;
          match_en = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(p_gap - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (match_en) begin
      for (int i = 0; i < 8; i++) begin
        if (nz_d[i] && (c_d[i] < CW'(p_spike_num)) && (nf_d[i] == NFW'(t_d))) begin
          ev_d[i+1] = 1'b1;
          nf_d[i]   = nf_d[i] + NFW'(p_isi);
          c_d[i]    = c_d[i] + 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      ev_q    <= '0;
      done_q  <= 1'b0;
      gap_q   <= '0;
      nz_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        nf_q[i] <= '0;
        c_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      ev_q    <= ev_d;
      done_q  <= done_d;
      gap_q   <= gap_d;
      nz_q    <= nz_d;
      for (int i = 0; i < 8; i++) begin
        nf_q[i] <= nf_d[i];
        c_q[i]  <= c_d[i];
      end
    end
  end

  assign o_event = ev_q;
  assign o_time  = t_q;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;

endmodule

// File: tb/tb_spike_encoder_8ch.sv
// Testbench for spike_encoder_8ch with default parameters.
module tb_spike_encoder_8ch;

  localparam int N     = 2;
  localparam int ISI   = 16;
  localparam int GAPC  = 4;
  localparam int FRAME = 256;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_v [8];
  logic [8:1] ev;
  logic [7:0] tm;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int obs_cnt   [8];
  int obs_first [8];
  int obs_last  [8];

  always #5 clk = ~clk;

  spike_encoder_8ch dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_intensity_1 (in_v[0]),
    .i_intensity_2 (in_v[1]),
    .i_intensity_3 (in_v[2]),
    .i_intensity_4 (in_v[3]),
    .i_intensity_5 (in_v[4]),
    .i_intensity_6 (in_v[5]),
    .i_intensity_7 (in_v[6]),
    .i_intensity_8 (in_v[7]),
    .o_event       (ev),
    .o_time        (tm),
    .o_busy        (busy),
    .o_done        (done)
  );

  // Runs one frame from the start request through the o_done cycle, checking
  // every cycle against a spike-time list built from the captured intensities.
  // Returns positioned at the negedge of the o_done cycle.
  task automatic run_frame(input bit repulse, input bit change5);
    logic [7:0] snap [8];
    logic [7:0] exp_ev [FRAME];
    logic [7:0] e_ev;
    logic [7:0] e_tm;
    logic       e_busy;
    logic       e_done;
    int         lat;
    int         tt;
    snap = in_v;
    for (int t = 0; t < FRAME; t++) exp_ev[t] = '0;
    for (int ch = 0; ch < 8; ch++) begin
      obs_cnt[ch]   = 0;
      obs_first[ch] = -1;
      obs_last[ch]  = -1;
      if (snap[ch] != 0) begin
        lat = 255 - int'(snap[ch]);
        for (int k = 0; k < N; k++) begin
          tt = lat + k * ISI;
          if (tt < FRAME) exp_ev[tt][ch] = 1'b1;
        end
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= FRAME + GAPC + 1; cyc++) begin
      if (cyc <= FRAME) begin
        e_ev = exp_ev[cyc-1]; e_tm = 8'(cyc - 1); e_busy = 1'b1; e_done = 1'b0;
      end else if (cyc <= FRAME + GAPC) begin
        e_ev = '0; e_tm = '0; e_busy = 1'b1; e_done = 1'b0;
      end else begin
        e_ev = '0; e_tm = '0; e_busy = 1'b0; e_done = 1'b1;
      end
      if (repulse) start = (cyc == 11) || (cyc == FRAME + 2);
      if (change5 && cyc == 6) in_v[0] = 8'd10;
      @(negedge clk);
      checks++;
      if (ev !== e_ev) begin
        failures++;
        $display("FAIL frame_event cyc=%0d got=%h exp=%h", cyc, ev, e_ev);
      end
      checks++;
      if (tm !== e_tm) begin
        failures++;
        $display("FAIL frame_time cyc=%0d got=%0d exp=%0d", cyc, tm, e_tm);
      end
      checks++;
      if (busy !== e_busy) begin
        failures++;
        $display("FAIL frame_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        failures++;
        $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, done, e_done);
      end
      for (int ch = 0; ch < 8; ch++) begin
        if (ev[ch+1] === 1'b1) begin
          obs_cnt[ch]++;
          if (obs_first[ch] < 0) obs_first[ch] = int'(tm);
          obs_last[ch] = int'(tm);
        end
      end
      if (cyc != FRAME + GAPC + 1) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    for (int ch = 0; ch < 8; ch++) in_v[ch] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ev !== 8'h00 || tm !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got ev=%h t=%0d busy=%b done=%b exp all zero", ev, tm, busy, done);
    end
    idle_cycle();
  endtask

  task automatic test_single();
    for (int ch = 0; ch < 8; ch++) in_v[ch] = '0;
    in_v[0] = 8'd255;
    run_frame(1'b0, 1'b0);
    checks++;
    if (obs_cnt[0] != 2 || obs_first[0] != 0 || obs_last[0] != 16) begin
      failures++;
      $display("FAIL single_ch1 got cnt=%0d first=%0d last=%0d exp 2/0/16", obs_cnt[0], obs_first[0], obs_last[0]);
    end
    checks++;
    if (obs_cnt[1] != 0) begin
      failures++;
      $display("FAIL single_ch2_silent got cnt=%0d exp 0", obs_cnt[1]);
    end
    idle_cycle();
  endtask

  task automatic test_boundary();
    for (int ch = 0; ch < 8; ch++) in_v[ch] = '0;
    in_v[2] = 8'd1;
    in_v[3] = 8'd128;
    run_frame(1'b0, 1'b0);
    checks++;
    if (obs_cnt[2] != 1 || obs_first[2] != 254) begin
      failures++;
      $display("FAIL boundary_ch3 got cnt=%0d first=%0d exp 1/254", obs_cnt[2], obs_first[2]);
    end
    checks++;
    if (obs_cnt[3] != 2 || obs_first[3] != 127 || obs_last[3] != 143) begin
      failures++;
      $display("FAIL boundary_ch4 got cnt=%0d first=%0d last=%0d exp 2/127/143", obs_cnt[3], obs_first[3], obs_last[3]);
    end
    idle_cycle();
  endtask

  task automatic test_all_channels();
    for (int ch = 0; ch < 8; ch++) in_v[ch] = 8'd200;
    run_frame(1'b0, 1'b0);
    for (int ch = 0; ch < 8; ch++) begin
      checks++;
      if (obs_cnt[ch] != 2 || obs_first[ch] != 55 || obs_last[ch] != 71) begin
        failures++;
        $display("FAIL all_ch%0d got cnt=%0d first=%0d last=%0d exp 2/55/71", ch + 1, obs_cnt[ch], obs_first[ch], obs_last[ch]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_ignore_start();
    for (int ch = 0; ch < 8; ch++) in_v[ch] = 8'(ch * 30 + 5);
    run_frame(1'b1, 1'b0);
    idle_cycle();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_after got done=%b busy=%b exp 0/0", done, busy);
    end
    idle_cycle();
  endtask

  task automatic test_change_intensity();
    for (int ch = 0; ch < 8; ch++) in_v[ch] = '0;
    in_v[0] = 8'd255;
    run_frame(1'b0, 1'b1);
    checks++;
    if (obs_cnt[0] != 2 || obs_last[0] != 16) begin
      failures++;
      $display("FAIL change_ignored got cnt=%0d last=%0d exp 2/16", obs_cnt[0], obs_last[0]);
    end
    idle_cycle();
    run_frame(1'b0, 1'b0);
    checks++;
    if (obs_cnt[0] != 1 || obs_first[0] != 245) begin
      failures++;
      $display("FAIL change_next_frame got cnt=%0d first=%0d exp 1/245", obs_cnt[0], obs_first[0]);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    for (int ch = 0; ch < 8; ch++) in_v[ch] = 8'($urandom_range(0, 255));
    run_frame(1'b0, 1'b0);
    // Still inside the o_done cycle: the next frame's start is accepted here.
    for (int ch = 0; ch < 8; ch++) in_v[ch] = 8'($urandom_range(0, 255));
    run_frame(1'b0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_random();
    int r;
    int lat;
    int exp_cnt;
    logic [7:0] snap [8];
    for (int f = 0; f < 5; f++) begin
      for (int ch = 0; ch < 8; ch++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      in_v[ch] = 8'd0;
        else if (r == 1) in_v[ch] = 8'd255;
        else             in_v[ch] = 8'($urandom_range(1, 254));
      end
      snap = in_v;
      run_frame(1'b0, 1'b0);
      for (int ch = 0; ch < 8; ch++) begin
        if (snap[ch] == 0) exp_cnt = 0;
        else begin
          lat = 255 - int'(snap[ch]);
          exp_cnt = (255 - lat) / ISI + 1;
          if (exp_cnt > N) exp_cnt = N;
        end
        checks++;
        if (obs_cnt[ch] != exp_cnt) begin
          failures++;
          $display("FAIL random_count f=%0d ch=%0d I=%0d got=%0d exp=%0d", f, ch + 1, snap[ch], obs_cnt[ch], exp_cnt);
        end
      end
      idle_cycle();
    end
  endtask

  task automatic test_reset_mid();
    for (int ch = 0; ch < 8; ch++) in_v[ch] = 8'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 51; cyc++) idle_cycle();
    @(negedge clk);
    checks++;
    if (tm !== 8'd50 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre got t=%0d busy=%b exp 50/1", tm, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ev !== 8'h00 || tm !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_post got ev=%h t=%0d busy=%b done=%b exp all zero", ev, tm, busy, done);
    end
    for (int k = 0; k < 10; k++) begin
      idle_cycle();
      @(negedge clk);
      checks++;
      if (ev !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet k=%0d got ev=%h done=%b busy=%b exp 0/0/0", k, ev, done, busy);
      end
    end
    idle_cycle();
    run_frame(1'b0, 1'b0);
    checks++;
    if (obs_cnt[0] != 2 || obs_first[0] != 55) begin
      failures++;
      $display("FAIL reset_mid_clean got cnt=%0d first=%0d exp 2/55", obs_cnt[0], obs_first[0]);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_all_channels();
    test_ignore_start();
    test_change_intensity();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
